// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage and its prefetch buffer.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INCR  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the two low bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: a request transfers on the edge where req & gnt; addr holds while req=1 and gnt=0.
// Each accepted request is answered by exactly one rvalid pulse carrying rdata, in order, one at a time.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit_buffer.sv
// Two-entry FIFO of {pc, instr} sitting between the memory response and the IF/ID register.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entries [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) entries[wr_ptr] <= push_data;
  end

  assign head = entries[rd_ptr];

  // Requests are only issued below full, so a push can never meet a full buffer.
  assert property (@(posedge clock) disable iff (!reset_n) !(push && !clear && count == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: single-outstanding memory fetch, 2-entry prefetch, redirect handling and IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          STALL_IFID_IN,
  input  logic          FLUSH_IFID_IN,
  input  logic          AltPCEnable_IN,
  input  logic [31:0]   AltPC_IN,
  fetch_unit_if.master  imem,
  output logic [31:0]   Instruction_OUT,
  output logic [31:0]   InstructionPC_OUT,
  output logic [31:0]   PCPlus4_OUT,
  output logic          Valid_OUT,
  output fetch_state_t  fsm_state,
  output logic [1:0]    buf_count
);

  localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [31:0]  inflight_pc, inflight_pc_next;
  logic         req_raw;
  logic         push;
  logic         pop;
  fetch_entry_t head;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_REQ;
      fetch_pc    <= RESET_PC;
      inflight_pc <= 32'h0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      inflight_pc <= inflight_pc_next;
    end
  end

  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    inflight_pc_next = inflight_pc;
    req_raw          = 1'b0;
    push             = 1'b0;
    case (state)
      ST_REQ: begin
        req_raw = (buf_count < FULL_COUNT);
        if (req_raw && imem.gnt) begin
          inflight_pc_next = fetch_pc;
          fetch_pc_next    = fetch_pc + PC_INCR;
          state_next       = AltPCEnable_IN ? ST_DISCARD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.rvalid) begin
          push       = !AltPCEnable_IN;
          state_next = ST_REQ;
        end else if (AltPCEnable_IN) begin
          state_next = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (imem.rvalid) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase
    // A redirect wins over the sequential fetch address.
    if (AltPCEnable_IN) fetch_pc_next = align_pc(AltPC_IN);
  end

  assign imem.req  = req_raw & RESET;
  assign imem.addr = fetch_pc;
  assign fsm_state = state;

  assign pop = !FLUSH_IFID_IN && !STALL_IFID_IN && (buf_count != 2'd0);

  fetch_buffer u_buffer (
    .clock     (CLOCK),
    .reset_n   (RESET),
    .push      (push),
    .push_data ('{pc: inflight_pc, instr: imem.rdata}),
    .pop       (pop),
    .clear     (AltPCEnable_IN),
    .head      (head),
    .count     (buf_count)
  );

  // IF/ID follows its own rules on a redirect edge too, so the delay-slot instruction survives.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      Valid_OUT         <= 1'b0;
      Instruction_OUT   <= NOP_WORD;
      InstructionPC_OUT <= 32'h0;
      PCPlus4_OUT       <= 32'h0;
    end else if (FLUSH_IFID_IN || (!STALL_IFID_IN && buf_count == 2'd0)) begin
      Valid_OUT         <= 1'b0;
      Instruction_OUT   <= NOP_WORD;
      InstructionPC_OUT <= 32'h0;
      PCPlus4_OUT       <= 32'h0;
    end else if (pop) begin
      Valid_OUT         <= 1'b1;
      Instruction_OUT   <= head.instr;
      InstructionPC_OUT <= head.pc;
      PCPlus4_OUT       <= head.pc + PC_INCR;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of memory, prefetch contents and IF/ID.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         redir = 1'b0;
  logic [31:0]  alt = 32'h0;
  logic [31:0]  instr_out, pc_out, pc4_out;
  logic         valid_out;
  fetch_state_t fsm_state;
  logic [1:0]   buf_count;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .CLOCK             (clock),
    .RESET             (reset_n),
    .STALL_IFID_IN     (stall),
    .FLUSH_IFID_IN     (flush),
    .AltPCEnable_IN    (redir),
    .AltPC_IN          (alt),
    .imem              (imem_bus),
    .Instruction_OUT   (instr_out),
    .InstructionPC_OUT (pc_out),
    .PCPlus4_OUT       (pc4_out),
    .Valid_OUT         (valid_out),
    .fsm_state         (fsm_state),
    .buf_count         (buf_count)
  );

  always #5 clock = ~clock;

  // Model: PCs waiting in the prefetch buffer, the memory transaction in flight, the IF/ID view.
  logic [31:0] exp_q[$];
  logic        m_out, m_drop;
  logic [31:0] m_out_addr, m_req_addr;
  int          m_wait;
  logic        m_valid;
  logic [31:0] m_pc, m_instr;
  int          lat_min, lat_max;
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid();
    check("ifid_valid", 32'(valid_out), 32'(m_valid));
    check("ifid_instr", instr_out, m_valid ? m_instr : NOP_WORD);
    if (m_valid) begin
      check("ifid_pc", pc_out, m_pc);
      check("ifid_pc4", pc4_out, m_pc + 32'd4);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_out = 1'b0; m_drop = 1'b0; m_out_addr = 32'h0; m_req_addr = 32'h0; m_wait = 0;
    m_valid = 1'b0; m_pc = 32'h0; m_instr = 32'h0;
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release on a later falling edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0;
    stall = 1'b0; flush = 1'b0; redir = 1'b0;
    #1;
    model_reset();
    check("rst_req", 32'(imem_bus.req), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_pc4", pc4_out, 32'h0);
    check("rst_count", 32'(buf_count), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_req", 32'(imem_bus.req), 32'h1);
    check("post_rst_addr", imem_bus.addr, 32'h0000_0000);
  endtask

  task automatic step(input logic s, input logic f, input logic r, input logic [31:0] a, input logic g);
    logic exp_req, resp, granted, pop, do_push;
    @(negedge clock);
    stall = s; flush = f; redir = r; alt = a; imem_bus.gnt = g;
    resp = 1'b0;
    if (m_out) begin
      m_wait--;
      resp = (m_wait == 0);
    end
    imem_bus.rvalid = resp;
    imem_bus.rdata  = resp ? mem_word(m_out_addr) : $urandom();
    #1;
    exp_req = !m_out && exp_q.size() < 2;
    check("req", 32'(imem_bus.req), 32'(exp_req));
    if (exp_req) check("addr", imem_bus.addr, m_req_addr);
    check("state", 32'(fsm_state), m_out ? (m_drop ? 32'd2 : 32'd1) : 32'd0);
    check("count", 32'(buf_count), 32'(exp_q.size()));
    @(posedge clock);
    granted = exp_req && g;
    pop = 1'b0;
    if (f || (!s && exp_q.size() == 0)) begin
      m_valid = 1'b0; m_pc = 32'h0; m_instr = 32'h0;
    end else if (!s) begin
      m_valid = 1'b1; m_pc = exp_q[0]; m_instr = mem_word(exp_q[0]); pop = 1'b1;
    end
    do_push = resp && !m_drop;
    if (r) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(m_out_addr);
    end
    if (resp) m_out = 1'b0;
    if (granted) begin
      m_out = 1'b1; m_out_addr = m_req_addr; m_drop = 1'b0;
      m_req_addr = m_req_addr + 32'd4;
      m_wait = $urandom_range(lat_min, lat_max);
    end
    if (r) begin
      if (m_out) m_drop = 1'b1;
      m_req_addr = {a[31:2], 2'b00};
    end
    #1;
    check_ifid();
  endtask

  initial begin
    int n;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
    lat_min = 1; lat_max = 1;
    do_reset();

    // Streaming with immediate grant and one-cycle responses.
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    check("first_valid_early", 32'(valid_out), 32'h0);
    step(0, 0, 0, 32'h0, 1);
    check("first_valid", 32'(valid_out), 32'h1);
    check("first_pc4", pc4_out, 32'h4);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 1);

    // Stall with memory always ready: buffer fills, request stops, IF/ID holds.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 1);

    // Redirect while a response is still pending.
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!(m_out && !m_drop && m_wait > 1) && n < 20) begin
      step(0, 0, 0, 32'h0, 1);
      n++;
    end
    check("wait_reached", 32'(m_out && !m_drop && m_wait > 1), 32'h1);
    step(0, 0, 1, 32'h0000_0100, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 1);

    // Redirect in the same cycle as a grant.
    lat_min = 1; lat_max = 1;
    n = 0;
    while (!(!m_out && exp_q.size() < 2) && n < 20) begin
      step(0, 0, 0, 32'h0, 0);
      n++;
    end
    check("req_reached", 32'(!m_out && exp_q.size() < 2), 32'h1);
    step(0, 0, 1, 32'h0000_0203, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 1);

    // Flush with stall while the buffer is full.
    n = 0;
    while (exp_q.size() < 2 && n < 20) begin
      step(1, 0, 0, 32'h0, 1);
      n++;
    end
    check("buf_full_reached", 32'(exp_q.size()), 32'd2);
    step(1, 1, 0, 32'h0, 1);
    check("flush_stall_count", 32'(buf_count), 32'd2);
    check("flush_stall_instr", instr_out, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 1);

    // Randomised traffic.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 11) == 0, $urandom(), $urandom_range(0, 3) != 0);

    // Grant withheld, then reset while the response is outstanding.
    lat_min = 5; lat_max = 5;
    n = 0;
    while (m_out && n < 20) begin
      step(0, 0, 0, 32'h0, 0);
      n++;
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 0);
    check("mid_wait_state", 32'(fsm_state), m_out ? 32'd1 : 32'd0);
    do_reset();
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
